// File: rtl/tank_move_ctrl.sv
// Tank movement controller: step-rate divider, turn-before-move, boundary
// saturation and a hit/respawn state machine for a single tank.
module tank_move_ctrl #(
   parameter int unsigned MOVE_DIV      = 25000000,
   parameter int unsigned RESPAWN_TICKS = 8,
   parameter int unsigned X_MAX         = 15,
   parameter int unsigned Y_MAX         = 21,
   parameter int unsigned X_INIT        = 7,
   parameter int unsigned Y_INIT        = 21,
   parameter logic [1:0]  DIR_INIT      = 2'b00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       tank_hit,
   output logic [4:0] x_rel_pos,
   output logic [4:0] y_rel_pos,
   output logic [1:0] tank_dir,
   output logic       tank_state,
   output logic       move_pulse
);

   localparam int unsigned     CntW     = $clog2(MOVE_DIV);
   localparam logic [CntW-1:0] CntLast  = CntW'(MOVE_DIV - 1);
   localparam logic [7:0]      DeadLast = 8'(RESPAWN_TICKS - 1);
   localparam logic [4:0]      XMax     = 5'(X_MAX);
   localparam logic [4:0]      YMax     = 5'(Y_MAX);
   localparam logic [4:0]      XInit    = 5'(X_INIT);
   localparam logic [4:0]      YInit    = 5'(Y_INIT);

   localparam logic [1:0] DirUp    = 2'b00;
   localparam logic [1:0] DirDown  = 2'b01;
   localparam logic [1:0] DirLeft  = 2'b10;
   localparam logic [1:0] DirRight = 2'b11;

   typedef enum logic [0:0] {StAlive, StDead} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      dead_q, dead_d;
   logic [4:0]      x_q, x_d, y_q, y_d;
   logic [1:0]      dir_q, dir_d;
   logic            pulse_q, pulse_d;
   logic            tick;
   logic            req_valid;
   logic [1:0]      req_dir;

   // Fixed-priority button decode: up > down > left > right.
   always_comb begin
      req_valid = btn_up | btn_down | btn_left | btn_right;
      if (btn_up) begin
         req_dir = DirUp;
      end else if (btn_down) begin
         req_dir = DirDown;
      end else if (btn_left) begin
         req_dir = DirLeft;
      end else begin
         req_dir = DirRight;
      end
   end

   // Step-rate divider; frozen while the game is paused.
   always_comb begin
      tick = enable && (cnt_q == CntLast);
      if (!enable) begin
         cnt_d = cnt_q;
      end else if (cnt_q == CntLast) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Next-state: hit beats a coincident tick; a mismatching request only turns.
   always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      pulse_d = 1'b0;
      if (enable) begin
         unique case (state_q)
            StAlive: begin
               if (tank_hit) begin
                  state_d = StDead;
                  dead_d  = '0;
               end else if (tick && req_valid) begin
                  if (req_dir != dir_q) begin
                     dir_d = req_dir;
                  end else begin
                     case (dir_q)
                        DirUp: if (y_q != 5'd0) begin
                           y_d     = y_q - 5'd1;
                           pulse_d = 1'b1;
                        end
                        DirDown: if (y_q != YMax) begin
                           y_d     = y_q + 5'd1;
                           pulse_d = 1'b1;
                        end
                        DirLeft: if (x_q != 5'd0) begin
                           x_d     = x_q - 5'd1;
                           pulse_d = 1'b1;
                        end
                        default: if (x_q != XMax) begin
                           x_d     = x_q + 5'd1;
                           pulse_d = 1'b1;
                        end
                     endcase
                  end
               end
            end
            StDead: begin
               if (tick) begin
                  if (dead_q == DeadLast) begin
                     state_d = StAlive;
                     x_d     = XInit;
                     y_d     = YInit;
                     dir_d   = DIR_INIT;
                  end else begin
                     dead_d = dead_q + 8'd1;
                  end
               end
            end
            default: state_d = StAlive;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StAlive;
         cnt_q   <= '0;
         dead_q  <= '0;
         x_q     <= XInit;
         y_q     <= YInit;
         dir_q   <= DIR_INIT;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dead_q  <= dead_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         pulse_q <= pulse_d;
      end
   end

   assign x_rel_pos  = x_q;
   assign y_rel_pos  = y_q;
   assign tank_dir   = dir_q;
   assign tank_state = (state_q == StAlive);
   assign move_pulse = pulse_q;

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Bench for tank_move_ctrl: directed scenarios with literal expectations,
// then randomized play, all compared every cycle against a behavioural model.
module tb_tank_move_ctrl;

   localparam int MoveDiv = 4;
   localparam int Respawn = 3;

   logic       clk = 1'b0;
   logic       rst_n, enable, btn_up, btn_down, btn_left, btn_right, tank_hit;
   logic [4:0] x_rel_pos, y_rel_pos;
   logic [1:0] tank_dir;
   logic       tank_state, move_pulse;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Model state (plain integers).
   int m_phase, m_x, m_y, m_dir, m_alive, m_pulse, m_dead_ticks;
   int dx[4] = '{0, 0, -1, 1};
   int dy[4] = '{-1, 1, 0, 0};

   tank_move_ctrl #(
      .MOVE_DIV     (MoveDiv),
      .RESPAWN_TICKS(Respawn),
      .X_MAX        (15),
      .Y_MAX        (21),
      .X_INIT       (7),
      .Y_INIT       (21),
      .DIR_INIT     (2'b00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .tank_hit  (tank_hit),
      .x_rel_pos (x_rel_pos),
      .y_rel_pos (y_rel_pos),
      .tank_dir  (tank_dir),
      .tank_state(tank_state),
      .move_pulse(move_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model, advanced on each rising edge with the sampled inputs.
   always @(posedge clk) begin
      int  req, nx, ny;
      bit  tick;
      if (!rst_n) begin
         m_phase = 0; m_x = 7; m_y = 21; m_dir = 0;
         m_alive = 1; m_pulse = 0; m_dead_ticks = 0;
      end else if (!enable) begin
         m_pulse = 0;
      end else begin
         tick    = (m_phase == MoveDiv - 1);
         m_phase = (m_phase + 1) % MoveDiv;
         m_pulse = 0;
         if (m_alive == 1) begin
            if (tank_hit) begin
               m_alive = 0;
               m_dead_ticks = 0;
            end else if (tick && (btn_up || btn_down || btn_left || btn_right)) begin
               req = btn_up ? 0 : btn_down ? 1 : btn_left ? 2 : 3;
               if (req != m_dir) begin
                  m_dir = req;
               end else begin
                  nx = m_x + dx[req];
                  ny = m_y + dy[req];
                  if (nx >= 0 && nx <= 15 && ny >= 0 && ny <= 21) begin
                     m_x = nx; m_y = ny; m_pulse = 1;
                  end
               end
            end
         end else if (tick) begin
            m_dead_ticks++;
            if (m_dead_ticks == Respawn) begin
               m_alive = 1; m_x = 7; m_y = 21; m_dir = 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("model_x", int'(x_rel_pos), m_x);
         chk("model_y", int'(y_rel_pos), m_y);
         chk("model_dir", int'(tank_dir), m_dir);
         chk("model_state", int'(tank_state), m_alive);
         chk("model_pulse", int'(move_pulse), m_pulse);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic btns(input bit u, input bit d, input bit l, input bit r);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b1; tank_hit = 1'b0;
      btns(0, 0, 0, 0);
      cyc(1);
      check_en = 1'b1;
      cyc(1);
      // Reset values.
      chk("rst_x", int'(x_rel_pos), 7);
      chk("rst_y", int'(y_rel_pos), 21);
      chk("rst_dir", int'(tank_dir), 0);
      chk("rst_state", int'(tank_state), 1);
      chk("rst_pulse", int'(move_pulse), 0);
      rst_n = 1'b1;

      // First tick on the 4th edge after release: three ticks of up.
      btns(1, 0, 0, 0);
      cyc(3);
      chk("pre_tick_y", int'(y_rel_pos), 21);
      cyc(1);
      chk("tick1_y", int'(y_rel_pos), 20);
      chk("tick1_pulse", int'(move_pulse), 1);
      cyc(1);
      chk("pulse_one_cycle", int'(move_pulse), 0);
      cyc(7);
      chk("tick3_y", int'(y_rel_pos), 18);
      chk("tick3_x", int'(x_rel_pos), 7);

      // Turn before move.
      btns(0, 0, 0, 1);
      cyc(4);
      chk("turn_dir", int'(tank_dir), 3);
      chk("turn_x", int'(x_rel_pos), 7);
      chk("turn_pulse", int'(move_pulse), 0);
      cyc(4);
      chk("right_x", int'(x_rel_pos), 8);
      chk("right_pulse", int'(move_pulse), 1);

      // Saturate at both x boundaries.
      btns(0, 0, 1, 0);
      cyc(4 * 11);
      chk("left_sat_x", int'(x_rel_pos), 0);
      chk("left_sat_pulse", int'(move_pulse), 0);
      btns(0, 0, 0, 1);
      cyc(4 * 18);
      chk("right_sat_x", int'(x_rel_pos), 15);
      chk("right_sat_pulse", int'(move_pulse), 0);

      // Priority: up over left; then idle.
      btns(1, 0, 1, 0);
      cyc(8);
      chk("prio_dir", int'(tank_dir), 0);
      chk("prio_y", int'(y_rel_pos), 17);
      chk("prio_x", int'(x_rel_pos), 15);
      btns(0, 0, 0, 0);
      cyc(8);
      chk("idle_y", int'(y_rel_pos), 17);

      // Hit coincident with a tick while holding up.
      btns(1, 0, 0, 0);
      cyc(3);
      tank_hit = 1'b1;
      cyc(1);
      tank_hit = 1'b0;
      chk("hit_state", int'(tank_state), 0);
      chk("hit_y", int'(y_rel_pos), 17);
      cyc(8);
      chk("dead_state", int'(tank_state), 0);
      cyc(4);
      chk("respawn_state", int'(tank_state), 1);
      chk("respawn_x", int'(x_rel_pos), 7);
      chk("respawn_y", int'(y_rel_pos), 21);
      chk("respawn_dir", int'(tank_dir), 0);

      // Reset mid-death.
      btns(0, 0, 0, 1);
      cyc(8);
      tank_hit = 1'b1;
      cyc(1);
      tank_hit = 1'b0;
      cyc(2);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      chk("middeath_rst_state", int'(tank_state), 1);
      chk("middeath_rst_x", int'(x_rel_pos), 7);
      chk("middeath_rst_dir", int'(tank_dir), 0);

      // Pause with buttons and a hit pulse.
      btns(1, 0, 0, 0);
      cyc(2);
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tank_hit = (i == 7);
         cyc(1);
      end
      tank_hit = 1'b0;
      chk("pause_state", int'(tank_state), 1);
      chk("pause_y", int'(y_rel_pos), 21);
      enable = 1'b1;
      cyc(2);
      chk("resume_y", int'(y_rel_pos), 20);

      // Randomized play.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0)
            btns(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tank_hit = ($urandom_range(0, 79) == 0);
         enable   = ($urandom_range(0, 9) != 0);
         rst_n    = ($urandom_range(0, 999) != 0);
         cyc(1);
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
